// File: rtl/flash_audio_player_if.sv
// Flash Avalon-MM read bus plus codec write port used by flash_audio_player.
// The master modport is the player side; the slave modport is the flash/codec side.
interface flash_audio_player_if #(
  parameter int unsigned ADDR_W   = 23,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SAMPLE_W = 16
);
  logic                flash_mem_read;
  logic [ADDR_W-1:0]   flash_mem_address;
  logic                flash_mem_waitrequest;
  logic [DATA_W-1:0]   flash_mem_readdata;
  logic                flash_mem_readdatavalid;
  logic                write_ready;
  logic                write_s;
  logic [SAMPLE_W-1:0] writedata_left;
  logic [SAMPLE_W-1:0] writedata_right;

  modport master (
    output flash_mem_read, flash_mem_address, write_s, writedata_left, writedata_right,
    input  flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid, write_ready
  );

  modport slave (
    input  flash_mem_read, flash_mem_address, write_s, writedata_left, writedata_right,
    output flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid, write_ready
  );
endinterface

// File: rtl/flash_audio_player.sv
// Streams packed samples from an Avalon flash window to the codec, mono or stereo, with volume.
// Define FLASH_AUDIO_LOOP_EN for continuous playback that wraps to START_ADDR.
module flash_audio_player #(
  parameter int unsigned       ADDR_W     = 23,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       SAMPLE_W   = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(23'h0FFFFF)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 stereo,
  input  logic [2:0]           vol_shift,
  output logic                 busy,
  output logic                 done,
  flash_audio_player_if.master bus
);
  localparam int unsigned SPW = DATA_W / SAMPLE_W;
  localparam int unsigned KW  = $clog2(SPW) + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_DATA, S_WAIT_RDY, S_SEND, S_HOLD, S_NEXT, S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_read;
  logic                r_write_s;
  logic [SAMPLE_W-1:0] r_left;
  logic [SAMPLE_W-1:0] r_right;
  logic                r_busy;
  logic                r_done;
  logic [DATA_W-1:0]   r_word;
  logic [KW-1:0]       r_k;

  logic [KW-1:0]       w_k1;
  logic                w_pair_ok;
  logic [SAMPLE_W-1:0] w_samp0;
  logic [SAMPLE_W-1:0] w_samp1;

  // Signed divide by 2^sh rounding toward zero: bias negatives by 2^sh-1 before the shift.
  function automatic logic [SAMPLE_W-1:0] f_scale(input logic [SAMPLE_W-1:0] x,
                                                  input logic [2:0] sh);
    logic signed [SAMPLE_W:0] v;
    logic signed [SAMPLE_W:0] bias;
    bias = x[SAMPLE_W-1] ? $signed(((SAMPLE_W+1)'(1) << sh) - (SAMPLE_W+1)'(1)) : '0;
    v    = $signed({x[SAMPLE_W-1], x}) + bias;
    v    = v >>> sh;
    return v[SAMPLE_W-1:0];
  endfunction

  assign w_k1      = r_k + KW'(1);
  assign w_pair_ok = (w_k1 < KW'(SPW));

  always_comb begin
    w_samp0 = '0;
    w_samp1 = '0;
    for (int unsigned i = 0; i < SPW; i++) begin
      if (r_k == KW'(i))  w_samp0 = r_word[i*SAMPLE_W +: SAMPLE_W];
      if (w_k1 == KW'(i)) w_samp1 = r_word[i*SAMPLE_W +: SAMPLE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_addr    <= START_ADDR;
      r_read    <= 1'b0;
      r_write_s <= 1'b0;
      r_left    <= '0;
      r_right   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_word    <= '0;
      r_k       <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_addr  <= START_ADDR;
            r_read  <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (!bus.flash_mem_waitrequest) begin
            r_read  <= 1'b0;
            r_state <= S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          if (bus.flash_mem_readdatavalid) begin
            r_word  <= bus.flash_mem_readdata;
            r_k     <= '0;
            r_state <= S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          if (!pause && bus.write_ready) r_state <= S_SEND;
        end
        S_SEND: begin
          if (!stereo) begin
            r_left    <= f_scale(w_samp0, vol_shift);
            r_right   <= f_scale(w_samp0, vol_shift);
            r_write_s <= 1'b1;
            r_k       <= w_k1;
            r_state   <= S_HOLD;
          end else if (w_pair_ok) begin
            r_left    <= f_scale(w_samp0, vol_shift);
            r_right   <= f_scale(w_samp1, vol_shift);
            r_write_s <= 1'b1;
            r_k       <= r_k + KW'(2);
            r_state   <= S_HOLD;
          end else begin
            // Unpaired trailing sample in stereo is dropped without a strobe.
            r_state <= S_NEXT;
          end
        end
        S_HOLD: begin
          if (!bus.write_ready) begin
            r_write_s <= 1'b0;
            r_state   <= (r_k < KW'(SPW)) ? S_WAIT_RDY : S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_addr == END_ADDR) begin
`ifdef FLASH_AUDIO_LOOP_EN
            r_addr  <= START_ADDR;
            r_read  <= 1'b1;
            r_state <= S_REQ;
`else
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
`endif
          end else begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_read  <= 1'b1;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.flash_mem_read    = r_read;
  assign bus.flash_mem_address = r_addr;
  assign bus.write_s           = r_write_s;
  assign bus.writedata_left    = r_left;
  assign bus.writedata_right   = r_right;
  assign busy                  = r_busy;
  assign done                  = r_done;
endmodule

// File: tb/tb_flash_audio_player.sv
// Randomized self-checking bench for flash_audio_player with flash and codec models.
// Expected writes come from an arithmetic reference model over the flash contents.
module tb_flash_audio_player;
  localparam int SPW = 2;
  localparam int SA  = 4;
  localparam int EA  = 5;

  logic       clk = 1'b0;
  logic       reset, start, pause, stereo;
  logic [2:0] vol_shift;
  logic       busy, done;

  flash_audio_player_if #(.ADDR_W(23), .DATA_W(32), .SAMPLE_W(16)) bus ();

  flash_audio_player #(
    .ADDR_W(23), .DATA_W(32), .SAMPLE_W(16), .START_ADDR(23'd4), .END_ADDR(23'd5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .stereo(stereo),
    .vol_shift(vol_shift), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [16];
  logic [31:0] wq[$];
  logic [31:0] expq[$];
  logic [22:0] accq[$];

  int fl_wait = 0, fl_delay = 0;
  int addr_viol = 0, rdrop_viol = 0, wd_viol = 0;
  bit bp_en = 0;
  int hold_lo = 0, hold_hi = 0;

  // Flash slave: waitrequest held fl_wait cycles, data fl_delay cycles after acceptance.
  initial begin
    int wcnt, pcnt;
    bit pend, acc_prev, rd_prev;
    logic [31:0] pdata;
    logic [22:0] rd_addr;
    wcnt = 0; pcnt = 0; pend = 0; acc_prev = 0; rd_prev = 0; pdata = '0; rd_addr = '0;
    bus.flash_mem_waitrequest = 1'b0;
    bus.flash_mem_readdatavalid = 1'b0;
    bus.flash_mem_readdata = '0;
    forever begin
      @(negedge clk);
      bus.flash_mem_readdatavalid = 1'b0;
      if (pend) begin
        if (pcnt == 0) begin
          bus.flash_mem_readdatavalid = 1'b1;
          bus.flash_mem_readdata = pdata;
          pend = 0;
        end else pcnt--;
      end
      if (acc_prev && bus.flash_mem_read) rdrop_viol++;
      acc_prev = 0;
      if (bus.flash_mem_read) begin
        if (!rd_prev) begin rd_addr = bus.flash_mem_address; wcnt = 0; end
        else if (bus.flash_mem_address !== rd_addr) addr_viol++;
        if (wcnt < fl_wait) begin
          bus.flash_mem_waitrequest = 1'b1;
          wcnt++;
        end else begin
          bus.flash_mem_waitrequest = 1'b0;
          acc_prev = 1; pend = 1; pcnt = fl_delay;
          pdata = mem[bus.flash_mem_address[3:0]];
          accq.push_back(bus.flash_mem_address);
        end
      end else bus.flash_mem_waitrequest = 1'b0;
      rd_prev = bus.flash_mem_read;
    end
  end

  // Codec: logs each strobe, keeps write_ready high hold cycles, then drops it once.
  initial begin
    int hcnt;
    bit ws_prev;
    logic [31:0] last;
    hcnt = 0; ws_prev = 0; last = '0;
    bus.write_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.write_s) begin
        if (!ws_prev) begin
          last = {bus.writedata_left, bus.writedata_right};
          wq.push_back(last);
          hcnt = int'($urandom_range(hold_lo, hold_hi));
        end else if ({bus.writedata_left, bus.writedata_right} !== last) wd_viol++;
        bus.write_ready = (hcnt != 0);
        if (hcnt != 0) hcnt--;
      end else begin
        bus.write_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      ws_prev = bus.write_s;
    end
  end

  function automatic int samp(input logic [31:0] w, input int k);
    logic [15:0] x;
    x = w[k*16 +: 16];
    return $signed(x);
  endfunction

  function automatic void build_exp(input bit st, input int vol);
    int k, l, r;
    logic [31:0] w;
    expq.delete();
    for (int a = SA; a <= EA; a++) begin
      w = mem[a];
      k = 0;
      while (k < SPW) begin
        if (!st) begin
          l = samp(w, k) / (1 << vol);
          expq.push_back({16'(l), 16'(l)});
          k += 1;
        end else begin
          if (k + 1 < SPW) begin
            l = samp(w, k) / (1 << vol);
            r = samp(w, k + 1) / (1 << vol);
            expq.push_back({16'(l), 16'(r)});
          end
          k += 2;
        end
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; pause = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_play(input bit st, input int vol, input bit do_pause, input string nm);
    bit ok, fin;
    int n;
    do_reset();
    build_exp(st, vol);
    wq.delete(); accq.delete();
    addr_viol = 0; rdrop_viol = 0; wd_viol = 0;
    stereo = st; vol_shift = 3'(vol);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (do_pause) begin
      for (int c = 0; c < 200; c++) begin
        @(posedge clk); #2;
        if (wq.size() >= 1) break;
      end
      pause = 1'b1;
      repeat (3) @(negedge clk);
      n = wq.size();
      repeat (20) @(negedge clk);
      #1;
      total++;
      if (wq.size() != n) begin bad++; $display("FAIL %s pause_writes: got %0d expected %0d", nm, wq.size(), n); end
      total++;
      if (n != 1) begin bad++; $display("FAIL %s pause_point: got %0d expected 1", nm, n); end
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL %s pause_busy: got %b expected 1", nm, busy); end
      pause = 1'b0;
    end
    ok = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
`ifdef FLASH_AUDIO_LOOP_EN
      fin = (accq.size() >= 3);
`else
      fin = (done === 1'b1);
`endif
      if (fin && wq.size() >= expq.size()) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL %s timeout: got %0d writes expected %0d", nm, wq.size(), expq.size()); end
    repeat (10) @(negedge clk);
    #1;
    for (int i = 0; i < expq.size(); i++) begin
      total++;
      if (i >= wq.size() || wq[i] !== expq[i])
        begin bad++; $display("FAIL %s write[%0d]: got %h expected %h", nm, i, (i < wq.size()) ? wq[i] : 32'hx, expq[i]); end
    end
    total++;
    if (accq[0] !== 23'(SA) || accq[1] !== 23'(EA))
      begin bad++; $display("FAIL %s read_addrs: got %h,%h expected %h,%h", nm, accq[0], accq[1], SA, EA); end
`ifdef FLASH_AUDIO_LOOP_EN
    total++;
    if (accq[2] !== 23'(SA)) begin bad++; $display("FAIL %s wrap_addr: got %h expected %h", nm, accq[2], SA); end
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL %s loop_flags: got busy=%b done=%b expected 1 0", nm, busy, done); end
`else
    total++;
    if (accq.size() != 2) begin bad++; $display("FAIL %s read_count: got %0d expected 2", nm, accq.size()); end
    total++;
    if (wq.size() != expq.size()) begin bad++; $display("FAIL %s write_count: got %0d expected %0d", nm, wq.size(), expq.size()); end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || bus.write_s !== 1'b0)
      begin bad++; $display("FAIL %s done_flags: got done=%b busy=%b ws=%b expected 1 0 0", nm, done, busy, bus.write_s); end
`endif
    total++;
    if (addr_viol != 0 || rdrop_viol != 0 || wd_viol != 0)
      begin bad++; $display("FAIL %s protocol: got addr=%0d rdrop=%0d wdata=%0d expected 0 0 0", nm, addr_viol, rdrop_viol, wd_viol); end
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clk); #1;
    total++;
    if (bus.flash_mem_read !== 1'b0) begin bad++; $display("FAIL reset_read: got %b expected 0", bus.flash_mem_read); end
    total++;
    if (bus.flash_mem_address !== 23'd4) begin bad++; $display("FAIL reset_addr: got %h expected 4", bus.flash_mem_address); end
    total++;
    if (bus.write_s !== 1'b0) begin bad++; $display("FAIL reset_ws: got %b expected 0", bus.write_s); end
    total++;
    if ({bus.writedata_left, bus.writedata_right} !== 32'h0)
      begin bad++; $display("FAIL reset_data: got %h expected 0", {bus.writedata_left, bus.writedata_right}); end
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_latency();
    int lat;
    fl_wait = 0; fl_delay = 0; bp_en = 0; hold_lo = 0; hold_hi = 0;
    do_reset();
    stereo = 1'b0; vol_shift = 3'd0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (bus.flash_mem_read !== 1'b1) begin bad++; $display("FAIL start_to_read: got %b expected 1", bus.flash_mem_read); end
    lat = 0;
    while (bus.write_s !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat != 4) begin bad++; $display("FAIL first_write_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_mono();
    fl_wait = 0; fl_delay = 0; bp_en = 0; hold_lo = 0; hold_hi = 1;
    mem[4] = 32'h8000_7FFF; mem[5] = $urandom;
    run_play(1'b0, 0, 1'b0, "mono");
    total++;
    if (wq[0] !== 32'h7FFF_7FFF || wq[1] !== 32'h8000_8000)
      begin bad++; $display("FAIL mono_word: got %h,%h expected 7fff7fff,80008000", wq[0], wq[1]); end
  endtask

  task automatic test_stereo();
    fl_wait = 0; fl_delay = 1; bp_en = 0; hold_lo = 0; hold_hi = 0;
    mem[4] = 32'hFFC0_0FC0; mem[5] = $urandom;
    run_play(1'b1, 6, 1'b0, "stereo");
    total++;
    if (wq[0] !== 32'h003F_FFFF) begin bad++; $display("FAIL stereo_word: got %h expected 003fffff", wq[0]); end
  endtask

  task automatic test_truncation();
    fl_wait = 0; fl_delay = 0; bp_en = 0; hold_lo = 0; hold_hi = 0;
    mem[4] = 32'hFFFD_FFFF; mem[5] = 32'h0003_FFFE;
    run_play(1'b0, 1, 1'b0, "trunc");
    total++;
    if (wq[0] !== 32'h0000_0000 || wq[1] !== 32'hFFFF_FFFF)
      begin bad++; $display("FAIL trunc_word: got %h,%h expected 00000000,ffffffff", wq[0], wq[1]); end
  endtask

  task automatic test_flash_wait();
    fl_wait = 5; fl_delay = 3; bp_en = 1; hold_lo = 0; hold_hi = 2;
    mem[4] = $urandom; mem[5] = $urandom;
    run_play(1'b0, int'($urandom_range(0, 7)), 1'b0, "flash_wait");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      fl_wait = int'($urandom_range(0, 3)); fl_delay = int'($urandom_range(0, 3));
      bp_en = 1; hold_lo = 0; hold_hi = 3;
      mem[4] = $urandom; mem[5] = $urandom;
      run_play(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'b0, "random");
    end
  endtask

  task automatic test_pause();
    fl_wait = 0; fl_delay = 0; bp_en = 0; hold_lo = 0; hold_hi = 0;
    mem[4] = $urandom; mem[5] = $urandom;
    run_play(1'b0, int'($urandom_range(0, 7)), 1'b1, "pause");
  endtask

  task automatic test_reset_hold();
    int n;
    fl_wait = 0; fl_delay = 0; bp_en = 0; hold_lo = 6; hold_hi = 6;
    do_reset();
    wq.delete(); accq.delete();
    stereo = 1'b0; vol_shift = 3'd0;
    mem[4] = 32'h1234_5678;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (wq.size() >= 1) break;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.write_s !== 1'b0 || bus.flash_mem_read !== 1'b0 || bus.flash_mem_address !== 23'd4)
      begin bad++; $display("FAIL hold_reset_bus: got ws=%b rd=%b addr=%h expected 0 0 4", bus.write_s, bus.flash_mem_read, bus.flash_mem_address); end
    total++;
    if ({bus.writedata_left, bus.writedata_right} !== 32'h0 || busy !== 1'b0 || done !== 1'b0)
      begin bad++; $display("FAIL hold_reset_regs: got data=%h busy=%b done=%b expected 0 0 0", {bus.writedata_left, bus.writedata_right}, busy, done); end
    @(negedge clk); reset = 1'b0;
    n = accq.size();
    repeat (15) @(negedge clk);
    #1;
    total++;
    if (wq.size() != 1 || accq.size() != n)
      begin bad++; $display("FAIL hold_reset_quiet: got writes=%0d reads=%0d expected 1 %0d", wq.size(), accq.size(), n); end
  endtask

  task automatic test_late_valid();
    fl_wait = 0; fl_delay = 4; bp_en = 0; hold_lo = 0; hold_hi = 0;
    do_reset();
    wq.delete(); accq.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (accq.size() >= 1) break;
    end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    total++;
    if (wq.size() != 0 || busy !== 1'b0 || bus.flash_mem_read !== 1'b0 || accq.size() != 1)
      begin bad++; $display("FAIL late_valid: got writes=%0d busy=%b rd=%b reads=%0d expected 0 0 0 1", wq.size(), busy, bus.flash_mem_read, accq.size()); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; stereo = 1'b0; vol_shift = 3'd0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    test_reset();
    test_latency();
    test_mono();
    test_stereo();
    test_truncation();
    test_flash_wait();
    test_random();
    test_pause();
    test_reset_hold();
    test_late_valid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/flash_audio_player.md
# flash_audio_player

Parametrised flash-to-codec sample streamer; successor to the single-purpose top-level player loop. Acts as an Avalon-MM read master on the flash core and fetches packed sample words from a configurable address window. Each word is unpacked into SAMPLE_W-bit signed samples, attenuated by a runtime power-of-two volume, and pushed to the audio codec's write interface in mono or stereo mode. Instantiated inside the board top level between `flash` and `audio_codec`.

## Interface
- ADDR_W, 23, flash word-address width
- DATA_W, 32, flash read-data width; must be an integer multiple of SAMPLE_W
- SAMPLE_W, 16, sample and codec data width
- START_ADDR, 0, first word address played (inclusive)
- END_ADDR, 23'h0FFFFF, last word address played (inclusive); must be ≥ START_ADDR
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high reset
- start  in  1  level; while high in IDLE or DONE, playback begins at START_ADDR
- pause  in  1  level; holds playback at the next sample boundary
- stereo  in  1  0 = mono (each sample to both channels); 1 = stereo (sample pairs L,R)
- vol_shift  in  3  attenuation exponent; output = sample / 2^vol_shift
- flash_mem_read  out  1  Avalon read request
- flash_mem_address  out  ADDR_W  Avalon word address
- flash_mem_waitrequest  in  1  Avalon wait request
- flash_mem_readdata  in  DATA_W  Avalon read data
- flash_mem_readdatavalid  in  1  Avalon read-data valid
- write_ready  in  1  codec FIFO can accept
- write_s  out  1  codec write strobe
- writedata_left  out  SAMPLE_W  left sample
- writedata_right  out  SAMPLE_W  right sample
- busy  out  1  high in any state other than IDLE/DONE
- done  out  1  high in DONE

## Operation
- SPW = DATA_W/SAMPLE_W. Sample k of a word = readdata[k*SAMPLE_W +: SAMPLE_W]; k = 0 is played first.
- States: IDLE, REQ, WAIT_DATA, WAIT_RDY, SEND, HOLD, NEXT, DONE.
- IDLE: start=1 → address ← START_ADDR, REQ.
- REQ: flash_mem_read=1 with the address held stable; on the cycle read=1 and waitrequest=0, go to WAIT_DATA; read drops next cycle.
- WAIT_DATA: on readdatavalid=1, capture the word and set k ← 0, then go to WAIT_RDY.
- WAIT_RDY: write_s=0. If pause=0 and write_ready=1, go to SEND; otherwise stay.
- SEND: drive the data and write_s=1, then go to HOLD. Mono: L = R = scale(sample k), k += 1. Stereo: L = scale(sample k), R = scale(sample k+1), k += 2.
- HOLD: write_s stays 1 until write_ready=0. On that cycle write_s ← 0. If k < SPW, go to WAIT_RDY; otherwise go to NEXT.
- NEXT: if address == END_ADDR, wrap (see Configuration). Otherwise address += 1 and go to REQ.
- DONE: start=1 restarts at START_ADDR. The start level is not edge-detected.
- scale(x): signed division by 2^vol_shift, truncating toward zero. This is not an arithmetic shift: scale(-1) at vol_shift=1 is 0, not -1. vol_shift=0 passes the sample through. vol_shift is sampled in SEND.
- Stereo with odd SPW: the final unpaired sample of each word is dropped.
- Reset values: flash_mem_read=0, flash_mem_address=START_ADDR, write_s=0, writedata_left=writedata_right=0, busy=0, done=0, state IDLE.
- Reset mid-operation: abandons any outstanding flash read or codec write with no further strobes. A late readdatavalid arriving in IDLE is ignored.

## Timing
- All outputs are registered. Changes of start, pause or stereo are seen one cycle later.
- Start to first flash_mem_read: 1 cycle. Zero-wait flash with readdatavalid one cycle after acceptance gives first write_s 4 cycles after start is sampled, provided write_ready=1.
- Per sample: minimum 3 cycles (WAIT_RDY, SEND, HOLD) plus however long write_ready stays high in HOLD.
- Exactly one flash read is outstanding at a time, and one write_s pulse corresponds to each codec write.
- pause during HOLD does not cut the strobe short. It takes effect at the following WAIT_RDY.
- Changing stereo mid-word takes effect at the next SEND.

## Configuration
- FLASH_AUDIO_LOOP_EN defined: NEXT at END_ADDR sets address ← START_ADDR and goes to REQ. Playback is continuous; done never asserts and busy stays 1.
- Not defined: NEXT at END_ADDR goes to DONE with done=1, busy=0 and write_s=0 until start.

## Test plan
- Mono, vol_shift=0, word 32'h8000_7FFF: writes L=R=16'h7FFF, then L=R=16'h8000. There are exactly 2 write_s pulses per word.
- Stereo, vol_shift=6, word 32'hFFC0_0FC0: one write with L=16'h003F and R=16'hFFFF (-64/64 = -1).
- Truncation: vol_shift=1, sample 16'hFFFF → 0, and sample 16'hFFFD → 16'hFFFF.
- Flash waitrequest held for 5 cycles and readdatavalid delayed 3 cycles: address is stable throughout, read deasserts the cycle after acceptance, and the data is captured correctly.
- START_ADDR=4, END_ADDR=5, no loop macro: reads addresses 4 and 5, then done=1 with no further reads. With FLASH_AUDIO_LOOP_EN, the next read is at address 4.
- pause asserted mid-word, and reset asserted in HOLD: no write_s while paused and resume at the next sample. After reset, all outputs return to their reset values on the next edge.
